// File: rtl/i2c_slave_tx_shifter.sv
// Transmit shift stage of the I2C slave: pops bytes from the TX FIFO and drives them
// MSB-first onto SDA (open-drain enable), then samples the master's ACK/NACK.
module i2c_slave_tx_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_tx,
  input  logic       scl_fall,
  input  logic       scl_rise,
  input  logic       sda_in,
  input  logic       stop_det,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       sda_oe,
  output logic       busy,
  output logic       underrun,
  output logic       nack_rcvd,
  output logic [7:0] tx_count
);

  localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WAIT_FALL, SHIFT, ACK
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        first_q, first_d;
  logic        sub_q, sub_d;
  logic [7:0]  tx_count_q, tx_count_d;
  logic        sda_oe_q, sda_oe_d;
  logic        rd_en_q, rd_en_d;
  logic        underrun_q, underrun_d;
  logic        nack_q, nack_d;
  logic        busy_q, busy_d;
  logic        enter_fetch;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    sub_d       = sub_q;
    tx_count_d  = tx_count_q;
    sda_oe_d    = sda_oe_q;
    rd_en_d     = 1'b0;
    underrun_d  = 1'b0;
    nack_d      = 1'b0;
    enter_fetch = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
          if (start_tx) begin
            tx_count_d  = 8'd0;
            first_d     = 1'b1;
            enter_fetch = 1'b1;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          shreg_d   = sub_q ? UNDERRUN_BYTE : fifo_data;
          bit_cnt_d = 3'd0;
          sub_d     = 1'b0;
          if (first_q) begin
            first_d  = 1'b0;
            sda_oe_d = ~shreg_d[7];
            state_d  = SHIFT;
          end else begin
            state_d = WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          sda_oe_d = 1'b0;
          if (scl_fall) begin
            sda_oe_d = ~shreg_q[7];
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_oe_d  = ~shreg_q[6];
            end
          end
        end
        ACK: begin
          // A simultaneous scl_fall makes the rise illegal; it is dropped.
          if (scl_rise && !scl_fall) begin
            if (!sda_in) begin
              tx_count_d  = tx_count_q + 8'd1;
              enter_fetch = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The pop decision is made on entry so the registered fifo_rd_en is high during FETCH.
    if (enter_fetch) begin
      state_d    = FETCH;
      rd_en_d    = ~fifo_empty;
      underrun_d = fifo_empty;
      sub_d      = fifo_empty;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      first_q    <= 1'b0;
      sub_q      <= 1'b0;
      tx_count_q <= 8'd0;
      sda_oe_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      underrun_q <= 1'b0;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      first_q    <= first_d;
      sub_q      <= sub_d;
      tx_count_q <= tx_count_d;
      sda_oe_q   <= sda_oe_d;
      rd_en_q    <= rd_en_d;
      underrun_q <= underrun_d;
      nack_q     <= nack_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;
  assign nack_rcvd  = nack_q;
  assign tx_count   = tx_count_q;

endmodule

// File: tb/tb_i2c_slave_tx_shifter.sv
// Self-checking bench for i2c_slave_tx_shifter: FIFO model, SCL master model and a
// scoreboard of expected transmitted bytes.
module tb_i2c_slave_tx_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_tx, scl_fall, scl_rise, sda_in, stop_det, fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en, sda_oe, busy, underrun, nack_rcvd;
  logic [7:0] tx_count;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int rd_cnt = 0, un_cnt = 0, nack_cnt = 0;

  i2c_slave_tx_shifter dut (
    .clk(clk), .rst(rst), .start_tx(start_tx), .scl_fall(scl_fall), .scl_rise(scl_rise),
    .sda_in(sda_in), .stop_det(stop_det), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .sda_oe(sda_oe), .busy(busy), .underrun(underrun),
    .nack_rcvd(nack_rcvd), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model and pulse counters, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      check("pop_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) fifo_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
    if (underrun)  un_cnt++;
    if (nack_rcvd) nack_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_tx);
    fq.push_back(b);
    fifo_empty = 1'b0;
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic pulse_fall();
    scl_fall = 1'b1; tick(); scl_fall = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulse_rise();
    scl_rise = 1'b1; tick(); scl_rise = 1'b0;
    repeat (4) tick();
  endtask

  // start_tx at E0; returns after E2 when bit 7 of the first byte is on the bus.
  task automatic start_byte();
    start_tx = 1'b1; tick(); start_tx = 1'b0;
    tick(); tick();
  endtask

  // Reads a byte whose bit 7 is already driven, then runs the ACK slot.
  task automatic read_byte(input bit ack, output logic [7:0] b);
    logic pre;
    for (int i = 0; i < 8; i++) begin
      b[7-i] = ~sda_oe;
      pre = sda_oe;
      pulse_rise();
      check("hold_on_rise", 32'(sda_oe), 32'(pre));
      pulse_fall();
    end
    check("ack_release", 32'(sda_oe), 32'd0);
    sda_in = ack ? 1'b0 : 1'b1;
    pulse_rise();
    sda_in = 1'b1;
    if (ack) begin
      check("wait_fall_low", 32'(sda_oe), 32'd0);
      pulse_fall();
    end
  endtask

  task automatic score(input logic [7:0] b);
    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else check("byte", 32'(b), 32'(exp_q.pop_front()));
  endtask

  initial begin
    logic [7:0] b;
    int r0, n0, u0;
    rst = 1'b1; start_tx = 0; scl_fall = 0; scl_rise = 0; sda_in = 1; stop_det = 0;
    fifo_empty = 1'b1; fifo_data = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_nack", 32'(nack_rcvd), 0);
    check("rst_tx_count", 32'(tx_count), 0);

    // Single byte A5, NACK.
    r0 = rd_cnt; n0 = nack_cnt;
    push(8'hA5, 1);
    start_byte();
    check("busy_tx", 32'(busy), 1);
    read_byte(0, b); score(b);
    check("a5_pops", 32'(rd_cnt - r0), 1);
    check("a5_nack", 32'(nack_cnt - n0), 1);
    check("a5_idle", 32'(busy), 0);
    check("a5_count", 32'(tx_count), 0);

    // Two bytes, ACK then NACK.
    r0 = rd_cnt; n0 = nack_cnt;
    push(8'h3C, 1); push(8'hC3, 1);
    start_byte();
    read_byte(1, b); score(b);
    read_byte(0, b); score(b);
    check("two_pops", 32'(rd_cnt - r0), 2);
    check("two_nack", 32'(nack_cnt - n0), 1);
    check("two_count", 32'(tx_count), 1);

    // Empty FIFO at start: underrun byte FF.
    r0 = rd_cnt; u0 = un_cnt;
    exp_q.push_back(8'hFF);
    start_byte();
    read_byte(0, b); score(b);
    check("ur_pops", 32'(rd_cnt - r0), 0);
    check("ur_pulse", 32'(un_cnt - u0), 1);

    // stop_det after the 4th bit of 00.
    r0 = rd_cnt;
    push(8'h00, 0);
    start_byte();
    for (int i = 0; i < 4; i++) begin pulse_rise(); pulse_fall(); end
    check("stop_pre_oe", 32'(sda_oe), 1);
    stop_det = 1'b1; tick(); stop_det = 1'b0;
    check("stop_oe", 32'(sda_oe), 0);
    check("stop_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin pulse_rise(); pulse_fall(); end
    check("stop_oe_after", 32'(sda_oe), 0);
    check("stop_pops", 32'(rd_cnt - r0), 1);

    // Asynchronous reset mid-byte while SDA is pulled low.
    r0 = rd_cnt;
    push(8'h00, 0); push(8'h55, 1);
    start_byte();
    pulse_rise(); pulse_fall();
    check("pre_rst_oe", 32'(sda_oe), 1);
    #3 rst = 1'b1;
    #1;
    check("arst_oe", 32'(sda_oe), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_rd_en", 32'(fifo_rd_en), 0);
    check("arst_tx_count", 32'(tx_count), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("arst_pops", 32'(rd_cnt - r0), 1);
    start_byte();
    read_byte(0, b); score(b);
    check("post_rst_pops", 32'(rd_cnt - r0), 2);

    // 256 ACKed FF bytes then a NACKed one; start_tx while busy is ignored.
    r0 = rd_cnt;
    for (int i = 0; i < 257; i++) push(8'hFF, 1);
    start_byte();
    for (int n = 0; n < 257; n++) begin
      if (n == 100) begin
        start_tx = 1'b1; tick(); start_tx = 1'b0;
        check("busy_start_count", 32'(tx_count), 100);
        check("busy_start_busy", 32'(busy), 1);
      end
      if (n == 255) check("count_255", 32'(tx_count), 255);
      read_byte(n < 256, b); score(b);
    end
    check("wrap_count", 32'(tx_count), 0);
    check("wrap_pops", 32'(rd_cnt - r0), 257);
    check("wrap_idle", 32'(busy), 0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_tx_shifter.md
# i2c_slave_tx_shifter

Transmit shift stage of the I2C slave, directly downstream of the TX FIFO. During a master-read transaction it pops bytes from the FIFO and drives them MSB-first onto SDA through an open-drain enable. It then samples the master's ACK/NACK and either fetches the next byte or stops. It operates on synchronized SCL edge strobes from the bus front end.

## Interface
- UNDERRUN_BYTE, 8'hFF: byte transmitted when the FIFO is empty at fetch time. 8'hFF leaves SDA released for the whole byte.
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start_tx  in  1  1-cycle pulse: own address matched with R/W=1; issued after the scl_fall that ends the address ACK slot
- scl_fall  in  1  1-cycle strobe, synchronized SCL falling edge
- scl_rise  in  1  1-cycle strobe, synchronized SCL rising edge
- sda_in  in  1  synchronized SDA level
- stop_det  in  1  1-cycle pulse: STOP or repeated START detected
- fifo_empty  in  1  TX FIFO empty flag
- fifo_data  in  8  TX FIFO registered read data, valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  1-cycle FIFO pop request; never asserted while fifo_empty=1
- sda_oe  out  1  1 = pull SDA low, 0 = release
- busy  out  1  high in every state except IDLE
- underrun  out  1  1-cycle pulse when UNDERRUN_BYTE is substituted
- nack_rcvd  out  1  1-cycle pulse when the master NACKs a byte
- tx_count  out  8  bytes ACKed since last start_tx; wraps 255->0

## Operation
- States: IDLE, FETCH, LOAD, WAIT_FALL, SHIFT, ACK.
- IDLE: sda_oe=0. On start_tx: clear tx_count, go to FETCH, set a first-byte flag.
- FETCH (1 cycle): if fifo_empty=0, assert fifo_rd_en. Otherwise pulse underrun and mark substitution. Go to LOAD.
- LOAD (1 cycle): capture fifo_data, or UNDERRUN_BYTE if marked, into an 8-bit shift register. Clear the bit counter.
  - First byte: drive sda_oe = ~shreg[7] on this same edge and go to SHIFT.
  - Any later byte: go to WAIT_FALL.
- WAIT_FALL: hold sda_oe=0. On scl_fall, drive sda_oe = ~shreg[7] and go to SHIFT.
- SHIFT: on each scl_fall, increment the bit counter and drive the next lower bit.
  - The scl_fall after bit 0 was driven releases SDA (sda_oe=0) and moves to ACK.
- ACK: on scl_rise, sample sda_in.
  - sda_in=0 (ACK): increment tx_count and go to FETCH.
  - sda_in=1 (NACK): pulse nack_rcvd and go to IDLE.
- stop_det in any state: next state is IDLE and sda_oe=0. stop_det has priority over every other input in the same cycle.
- start_tx outside IDLE: ignored.
- scl_fall and scl_rise in the same cycle (illegal): ignore scl_rise.
- Reset, including mid-byte: all outputs go to 0, state goes to IDLE, shift register and counters clear. No FIFO pop occurs during or after reset.

## Timing
- All outputs are registered.
- Reset values: fifo_rd_en=0, sda_oe=0, busy=0, underrun=0, nack_rcvd=0, tx_count=0.
- Edge numbering: start_tx is sampled at edge E0.
  - fifo_rd_en is high in cycle E0–E1; the FIFO updates its output at E1.
  - The shift register loads at E2; sda_oe shows bit 7 from E2.
- Later bytes: the ACK scl_rise sampled at edge R gives fifo_rd_en in R–R+1 and a load at R+2. Bit 7 appears on the first scl_fall after R+2.
- Precondition: SCL edge strobes are ≥4 clk apart, so each fetch completes before the next scl_fall.
- sda_oe changes only on scl_fall edges or on load of the first byte. It never changes on an scl_rise edge.
- Exactly one fifo_rd_en pulse per byte. No pulse if fifo_empty=1 in FETCH.

## Test plan
- Single byte 8'hA5 in FIFO, start_tx, 9 SCL cycles with NACK.
  - Required: one fifo_rd_en pulse; sda_oe sequence 0,1,0,1,1,0,1,0; release in the ACK slot; nack_rcvd pulse; IDLE; tx_count=0.
- FIFO holds 8'h3C and 8'hC3, master ACKs then NACKs.
  - Required: two fifo_rd_en pulses; both bytes transmitted correctly; tx_count=1; bit 7 of byte 2 appears only after the scl_fall that ends the ACK slot.
- Empty FIFO at start_tx.
  - Required: no fifo_rd_en; underrun pulse; sda_oe=0 for all 8 bits (8'hFF).
- stop_det after the 4th bit of 8'h00.
  - Required: sda_oe=0 the next cycle; busy=0; no further fifo_rd_en.
- rst asserted mid-byte while sda_oe=1.
  - Required: sda_oe=0 immediately (asynchronous); all outputs at reset values; a later start_tx transmits the next FIFO byte cleanly.
- 256 ACKed 8'hFF bytes.
  - Required: tx_count wraps to 0; start_tx issued while busy has no effect.
